// File: rtl/fifo_frame_packer.sv
// ---------------------------------------------------------------------------
// fifo_frame_packer
//
// Drains the show-ahead sample FIFO directly upstream and emits framed words
// on a valid/ready stream:
//   header {8'hA5, seq, 8'h00, len}, len payload samples, optional trailer
//   holding the XOR of the payload samples (m_last marks the final word).
// A frame starts only once the FIFO already holds len samples, so the FIFO
// cannot run dry in the middle of a frame.
//
// Build option:
//   FRAME_PACKER_TRAILER_EN  defined   -> XOR checksum trailer word appended
//                            undefined -> no trailer, m_last on last payload
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   enable           permits new frames to start
//   frame_len        samples per frame, captured at frame start
//   abort            synchronous abort (same source as the FIFO flush)
//   fifo_data        FIFO head word (valid while fifo_data_rdy)
//   fifo_data_rdy    FIFO non-empty
//   fifo_size        FIFO occupancy
//   fifo_rd          combinational pop strobe to the FIFO
//   m_data/m_valid/m_ready/m_last   output stream
//   busy             not idle
//   cfg_err          frame_len is 0 or larger than the FIFO depth
//   abort_err        sticky: a frame was aborted
//   frame_cnt        completed frames (wraps)
// ---------------------------------------------------------------------------
module fifo_frame_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 5,
    localparam int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [7:0]               frame_len,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    fifo_data,
    input  logic                     fifo_data_rdy,
    input  logic [FIFO_SIZE_WIDTH:0] fifo_size,
    output logic                     fifo_rd,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     abort_err,
    output logic [15:0]              frame_cnt
);

    localparam logic [7:0] MAX_LEN = 8'(FIFO_SIZE);

`ifdef FRAME_PACKER_TRAILER_EN
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
`endif

    state_t      state;
    logic [7:0]  len;
    logic [7:0]  remaining;
    logic [7:0]  seq;
    logic [7:0]  fifo_size_ext;
    logic        pop;
    logic        start_ok;
`ifdef FRAME_PACKER_TRAILER_EN
    logic [DATA_WIDTH-1:0] chk;
`endif

    function automatic logic [DATA_WIDTH-1:0] build_header(input logic [7:0] s,
                                                           input logic [7:0] l);
        return {8'hA5, s, 8'h00, l};
    endfunction

    assign fifo_size_ext = 8'(fifo_size);

    // The frame_len != 0 term covers the single cycle before the registered
    // cfg_err catches up with a frame_len that has just dropped to zero.
    assign start_ok = enable && !cfg_err && !abort && (frame_len != 8'd0) &&
                      (fifo_size_ext >= frame_len);

    // Pop whenever the output register is free (empty or being accepted this
    // cycle), so payload streams at one word per clock under full ready.
    always_comb begin
        pop = 1'b0;
        if (state == PAYLOAD && !abort && remaining != 8'd0 && fifo_data_rdy &&
            (!m_valid || m_ready))
            pop = 1'b1;
    end

    assign fifo_rd = pop;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            len       <= 8'd0;
            remaining <= 8'd0;
            seq       <= 8'd0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            cfg_err   <= 1'b0;
            abort_err <= 1'b0;
            frame_cnt <= 16'd0;
`ifdef FRAME_PACKER_TRAILER_EN
            chk       <= '0;
`endif
        end else begin
            cfg_err <= (frame_len == 8'd0) || (frame_len > MAX_LEN);

            if (abort && state != IDLE) begin
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
                abort_err <= 1'b1;
                state     <= IDLE;
`ifdef FRAME_PACKER_TRAILER_EN
                chk       <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            len   <= frame_len;
                            state <= HEADER;
                        end
                    end

                    // Header is loaded here and accepted while in PAYLOAD,
                    // where its acceptance edge also pops the first sample.
                    HEADER: begin
                        m_data    <= build_header(seq, len);
                        m_valid   <= 1'b1;
                        m_last    <= 1'b0;
                        remaining <= len;
                        state     <= PAYLOAD;
                    end

                    PAYLOAD: begin
                        if (pop) begin
                            m_data    <= fifo_data;
                            m_valid   <= 1'b1;
                            remaining <= remaining - 8'd1;
`ifdef FRAME_PACKER_TRAILER_EN
                            chk       <= chk ^ fifo_data;
                            if (remaining == 8'd1)
                                state <= TRAILER;
`else
                            m_last    <= (remaining == 8'd1);
`endif
                        end else if (m_valid && m_ready) begin
                            m_valid <= 1'b0;
`ifndef FRAME_PACKER_TRAILER_EN
                            if (m_last) begin
                                m_last    <= 1'b0;
                                seq       <= seq + 8'd1;
                                frame_cnt <= frame_cnt + 16'd1;
                                state     <= IDLE;
                            end
`endif
                        end
                    end

`ifdef FRAME_PACKER_TRAILER_EN
                    // m_last distinguishes "last payload word pending" from
                    // "trailer pending".
                    TRAILER: begin
                        if (!m_last) begin
                            if (!m_valid || m_ready) begin
                                m_data  <= chk;
                                m_valid <= 1'b1;
                                m_last  <= 1'b1;
                            end
                        end else if (m_ready) begin
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            seq       <= seq + 8'd1;
                            frame_cnt <= frame_cnt + 16'd1;
                            chk       <= '0;
                            state     <= IDLE;
                        end
                    end
`endif

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_fifo_frame_packer
//
// Self-checking bench for fifo_frame_packer. A queue-based FIFO feeds the
// DUT; a reference model builds the expected word stream of each frame from
// the frame rules (header, the next len samples in FIFO order, optional XOR
// trailer) and a monitor compares every accepted word, holds under
// backpressure and pop counts against it.
// ---------------------------------------------------------------------------
module tb_fifo_frame_packer;

    localparam int DATA_WIDTH = 32;
    localparam int FIFO_SIZE  = 5;
    localparam int FSW        = $clog2(FIFO_SIZE);

    typedef logic [FSW:0] fsz_t;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  enable;
    logic [7:0]            frame_len;
    logic                  abort;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_data_rdy;
    logic [FSW:0]          fifo_size;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic                  m_last;
    logic                  busy;
    logic                  cfg_err;
    logic                  abort_err;
    logic [15:0]           frame_cnt;

    fifo_frame_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_SIZE  (FIFO_SIZE)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .frame_len     (frame_len),
        .abort         (abort),
        .fifo_data     (fifo_data),
        .fifo_data_rdy (fifo_data_rdy),
        .fifo_size     (fifo_size),
        .fifo_rd       (fifo_rd),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .abort_err     (abort_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- upstream FIFO ----------------
    logic [31:0] fifo_q[$];
    logic        pop_s;
    logic        flush_s;

    task automatic fifo_drive();
        fifo_data_rdy = (fifo_q.size() != 0);
        fifo_data     = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        fifo_size     = fsz_t'(fifo_q.size());
    endtask

    always @(posedge clk) begin
        pop_s   = fifo_rd;
        flush_s = abort;
        #1;
        if (flush_s)
            fifo_q.delete();
        else if (pop_s && fifo_q.size() != 0)
            void'(fifo_q.pop_front());
        fifo_drive();
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_src[$];
    logic [32:0] exp_q[$];
    logic [7:0]  m_seq     = 8'd0;
    logic [15:0] m_frames  = 16'd0;
    int          exp_pops  = 0;
    int          pop_cnt   = 0;

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        ref_src.push_back(w);
        fifo_drive();
    endtask

    function automatic int frame_words(input int len);
`ifdef FRAME_PACKER_TRAILER_EN
        return len + 2;
`else
        return len + 1;
`endif
    endfunction

    task automatic expect_frame(input int len);
        logic [31:0] x;
        logic [31:0] w;
        x = 32'h0;
        exp_q.push_back({1'b0, 8'hA5, m_seq, 8'h00, 8'(len)});
        for (int i = 0; i < len; i++) begin
            w = ref_src.pop_front();
            x = x ^ w;
`ifdef FRAME_PACKER_TRAILER_EN
            exp_q.push_back({1'b0, w});
`else
            exp_q.push_back({(i == len - 1), w});
`endif
        end
`ifdef FRAME_PACKER_TRAILER_EN
        exp_q.push_back({1'b1, x});
`endif
        m_seq    = m_seq + 8'd1;
        m_frames = m_frames + 16'd1;
        exp_pops += len;
    endtask

    // ---------------- consumer ready ----------------
    int         ready_mode = 0;   // 0 fixed, 1 random, 2 pattern 1,0,0,1
    logic       ready_val  = 1'b1;
    logic [3:0] ready_pat  = 4'b1001;
    int         pat_idx    = 0;

    always @(negedge clk) begin
        #1;
        case (ready_mode)
            0: m_ready = ready_val;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                m_ready = ready_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
        endcase
        if (ready_mode != 2)
            pat_idx = 0;
    end

    // ---------------- monitor ----------------
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [32:0] e;

    always @(negedge clk) begin
        #3;
        if (!rstn) begin
            hold_pending = 1'b0;
        end else begin
            if (fifo_rd)
                pop_cnt++;
            if (hold_pending) begin
                check_eq("hold_valid", 64'(m_valid), 64'(1));
                check_eq("hold_data", 64'(m_data), 64'(hold_data));
                check_eq("hold_last", 64'(m_last), 64'(hold_last));
            end
            hold_pending = m_valid && !m_ready && !abort;
            hold_data    = m_data;
            hold_last    = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 64'(m_data), 64'(0) - 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("word_data", 64'(m_data), 64'(e[31:0]));
                    check_eq("word_last", 64'(m_last), 64'(e[32]));
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy)
                break;
        end
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    int vcount;
    int nlen;

    initial begin
        rstn      = 1'b0;
        enable    = 1'b0;
        abort     = 1'b0;
        frame_len = 8'd2;
        fifo_drive();
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 64'(m_valid), 64'(0));
        check_eq("rst_data", 64'(m_data), 64'(0));
        check_eq("rst_last", 64'(m_last), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_fifo_rd", 64'(fifo_rd), 64'(0));
        check_eq("rst_abort_err", 64'(abort_err), 64'(0));
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_cfg_err", 64'(cfg_err), 64'(0));

        // basic frame, latency and throughput
        push_word(32'h1);
        push_word(32'h2);
        frame_len = 8'd2;
        enable    = 1'b1;
        expect_frame(2);
        @(negedge clk);
        check_eq("t1_busy", 64'(busy), 64'(1));
        check_eq("t1_early_valid", 64'(m_valid), 64'(0));
        @(negedge clk);
        check_eq("t1_hdr_valid", 64'(m_valid), 64'(1));
        check_eq("t1_hdr", 64'(m_data), 64'(32'hA5000002));
        vcount = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) vcount++;
            else break;
        end
        check_eq("t1_consecutive", 64'(vcount), 64'(frame_words(2)));
        wait_idle("t1");
        check_eq("t1_frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check_eq("t1_pops", 64'(pop_cnt), 64'(exp_pops));

        // not enough data: wait, then start once the third word arrives
        enable    = 1'b0;
        push_word(32'hAAAA0001);
        push_word(32'hAAAA0002);
        frame_len = 8'd3;
        enable    = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t2_wait_busy", 64'(busy), 64'(0));
        check_eq("t2_wait_pops", 64'(pop_cnt), 64'(exp_pops));
        push_word(32'hAAAA0003);
        expect_frame(3);
        wait_idle("t2");
        check_eq("t2_frame_cnt", 64'(frame_cnt), 64'(m_frames));

        // backpressure 1,0,0,1
        enable = 1'b0;
        push_word(32'h4);
        push_word(32'h5);
        frame_len  = 8'd2;
        ready_mode = 2;
        enable     = 1'b1;
        expect_frame(2);
        wait_idle("t3");
        check_eq("t3_pops", 64'(pop_cnt), 64'(exp_pops));
        ready_mode = 0;
        ready_val  = 1'b1;

        // configuration errors
        enable    = 1'b0;
        frame_len = 8'd0;
        @(negedge clk);
        check_eq("cfg_len0", 64'(cfg_err), 64'(1));
        frame_len = 8'd5;
        @(negedge clk);
        check_eq("cfg_len5", 64'(cfg_err), 64'(0));
        frame_len = 8'd6;
        @(negedge clk);
        check_eq("cfg_len6", 64'(cfg_err), 64'(1));
        frame_len = 8'd0;
        @(negedge clk);
        push_word(32'h11);
        push_word(32'h22);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("cfg0_busy", 64'(busy), 64'(0));
        frame_len = 8'd6;
        push_word(32'h33);
        push_word(32'h44);
        push_word(32'h55);
        repeat (4) @(negedge clk);
        check_eq("cfg6_busy", 64'(busy), 64'(0));
        check_eq("cfg_pops", 64'(pop_cnt), 64'(exp_pops));

        // abort in IDLE flushes the FIFO but leaves flags alone
        enable = 1'b0;
        abort  = 1'b1;
        ref_src.delete();
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_err", 64'(abort_err), 64'(0));
        check_eq("idle_abort_busy", 64'(busy), 64'(0));

        // abort after header acceptance
        frame_len = 8'd3;
        push_word(32'hC1);
        push_word(32'hC2);
        push_word(32'hC3);
        enable = 1'b1;
        exp_q.push_back({1'b0, 8'hA5, m_seq, 8'h00, 8'd3});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check_eq("abort_hdr_seen", 64'(exp_q.size()), 64'(0));
        exp_pops += 1;
        abort     = 1'b1;
        ready_val = 1'b0;
        enable    = 1'b0;
        ref_src.delete();
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_valid", 64'(m_valid), 64'(0));
        check_eq("abort_last", 64'(m_last), 64'(0));
        check_eq("abort_err_set", 64'(abort_err), 64'(1));
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check_eq("abort_pops", 64'(pop_cnt), 64'(exp_pops));
        repeat (2) @(negedge clk);
        check_eq("abort_err_sticky", 64'(abort_err), 64'(1));

        // reset in the middle of a frame
        push_word(32'hD1);
        push_word(32'hD2);
        frame_len = 8'd2;
        enable    = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("midrst_busy_before", 64'(busy), 64'(1));
        rstn = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(m_valid), 64'(0));
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_abort_err", 64'(abort_err), 64'(0));
        check_eq("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        check_eq("midrst_data", 64'(m_data), 64'(0));
        @(negedge clk);
        fifo_q.delete();
        ref_src.delete();
        exp_q.delete();
        fifo_drive();
        m_seq    = 8'd0;
        m_frames = 16'd0;
        pop_cnt  = 0;
        exp_pops = 0;
        enable   = 1'b0;
        frame_len = 8'd1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // 256 single-sample frames: seq wraps, frame_cnt reaches 256
        ready_mode = 1;
        enable     = 1'b1;
        for (int f = 0; f < 256; f++) begin
            push_word($urandom);
            expect_frame(1);
            wait_idle("wrap");
        end
        check_eq("wrap_frame_cnt", 64'(frame_cnt), 64'(256));
        check_eq("wrap_pops", 64'(pop_cnt), 64'(exp_pops));

        // random lengths, enable drop and frame_len change mid-frame,
        // extra FIFO writes during a frame
        enable = 1'b0;
        for (int f = 0; f < 40; f++) begin
            nlen = $urandom_range(1, 5);
            while (fifo_q.size() < nlen)
                push_word($urandom);
            frame_len = 8'(nlen);
            enable    = 1'b1;
            expect_frame(nlen);
            repeat (2) @(negedge clk);
            enable    = 1'b0;
            frame_len = 8'($urandom_range(0, 255));
            if (fifo_q.size() < FIFO_SIZE && $urandom_range(0, 1) == 1)
                push_word($urandom);
            wait_idle("rand");
        end
        check_eq("rand_frame_cnt", 64'(frame_cnt), 64'(m_frames));
        check_eq("rand_pops", 64'(pop_cnt), 64'(exp_pops));
        check_eq("rand_abort_err", 64'(abort_err), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
Name: fifo_frame_packer

Overview:
- Drains the sample FIFO, which sits directly upstream, and emits framed words on a valid/ready stream toward the host-side transport.
- Each frame is: one header word, then exactly frame_len samples, then one XOR checksum trailer word (trailer is optional, see Optional Feature).
- A frame starts only when the FIFO already holds a full frame, so the FIFO never underruns mid-frame.

Parameters:
- DATA_WIDTH, 32: sample and stream word width; must be 32 (header layout depends on it).
- FIFO_SIZE, 5: depth of the upstream FIFO.
- FIFO_SIZE_WIDTH, $clog2(FIFO_SIZE): derived (localparam).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  permits new frames to start.
- frame_len  in  8  samples per frame; sampled at frame start.
- abort  in  1  synchronous abort; tie to the same source as the FIFO's flush_fifo.
- fifo_data  in  DATA_WIDTH  FIFO head word; valid while fifo_data_rdy=1 (show-ahead).
- fifo_data_rdy  in  1  FIFO non-empty.
- fifo_size  in  FIFO_SIZE_WIDTH+1  current FIFO occupancy.
- fifo_rd  out  1  combinational pop strobe; drives the FIFO's out_data_vld.
- m_data  out  DATA_WIDTH  stream word.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the consumer.
- m_last  out  1  marks the final word of a frame.
- busy  out  1  high whenever state is not IDLE.
- cfg_err  out  1  frame_len is 0 or greater than FIFO_SIZE.
- abort_err  out  1  sticky: a frame was aborted; cleared only by reset.
- frame_cnt  out  16  number of completed frames; wraps.

Behaviour:
- Reset values: fifo_rd=0, m_data=0, m_valid=0, m_last=0, busy=0, cfg_err=0, abort_err=0, frame_cnt=0, seq=0, state=IDLE.
- Stream rules:
  - Once m_valid=1, m_data, m_valid and m_last hold until m_valid&&m_ready.
  - The output is a single register. It may reload in the same cycle it is accepted, giving one word per clock at full throughput.
- fifo_rd is asserted only when fifo_data_rdy=1. Each pop loads fifo_data into m_data on that same edge.
- cfg_err is registered: it equals (frame_len==0 || frame_len>FIFO_SIZE), updated every cycle.
- States:
  - IDLE: if enable && !cfg_err && !abort && fifo_size>=frame_len, latch len=frame_len and go to HEADER. No output activity in IDLE.
  - HEADER: load m_data={8'hA5, seq[7:0], 8'h00, len}, m_valid=1, m_last=0. When accepted, go to PAYLOAD with remaining=len.
  - PAYLOAD: when (!m_valid || m_ready) && remaining>0, then fifo_rd=1, m_data<=fifo_data, m_valid<=1, remaining decrements, and chk^=fifo_data.
    - With the trailer, m_last stays 0 for every payload word.
    - After the last pop, go to TRAILER.
  - TRAILER: when the last payload word is accepted, load m_data=chk, m_valid=1, m_last=1.
    - When the trailer is accepted: m_valid=0, seq+1 (wraps 255→0), frame_cnt+1, chk=0, go to IDLE.
- Latency:
  - From enable with a full frame present, the header is presented 2 cycles later.
  - With m_ready held at 1, a frame takes len+2 consecutive valid cycles.
- Boundaries:
  - enable dropping mid-frame: the current frame completes normally.
  - Changes to frame_len mid-frame are ignored until the next frame.
  - fifo_data_rdy=0 in PAYLOAD (only possible if the FIFO misbehaves): no pop, wait.
  - New FIFO writes during a frame are harmless.
  - abort in any non-IDLE state: next edge sets m_valid=0, m_last=0, chk=0, abort_err=1, state=IDLE. seq and frame_cnt are not incremented. fifo_rd is forced 0 in the abort cycle.
  - abort in IDLE: no effect on flags.
  - Reset mid-frame: everything returns immediately to reset values; seq restarts at 0.

Optional Feature:
- Macro: FRAME_PACKER_TRAILER_EN.
- Defined: trailer word present, behaviour as above.
- Undefined:
  - No TRAILER state and no checksum logic.
  - m_last=1 on the final payload word.
  - seq and frame_cnt update on acceptance of that word.
  - A frame is len+1 words.

Test Plan:
- Reset, then write 32'h1 and 32'h2; frame_len=2, enable=1, m_ready=1 → header 32'hA5000002, then 1, 2, then trailer 32'h00000003 with m_last=1; frame_cnt=1; exactly 2 fifo_rd pulses.
- frame_len=3 with only 2 words in the FIFO → stays IDLE, busy=0, no fifo_rd. Write a third word → frame starts; header seq byte=8'h01.
- Backpressure: frame_len=2, data 4 and 5, m_ready toggling 1,0,0,1 → each word is held stable while m_ready=0; no extra pops; trailer=32'h1.
- frame_len=0 → cfg_err=1 next cycle, no frame. frame_len=6 → cfg_err=1.
- Assert abort for 1 cycle after the header is accepted (len=3) → m_valid=0, abort_err=1, state IDLE, frame_cnt unchanged.
- Run 256 frames of len=1 → the seq byte wraps from 8'hFF to 8'h00 and frame_cnt=256.
